// File: rtl/md_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_sched_if
//  Description : Issue / HI-LO access bundle between the MIPS pipeline and
//                the iterative multiply/divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_sched_if #(
   parameter int W = 32
);
   logic         md_start;
   logic         md_op;
   logic [W-1:0] md_a;
   logic [W-1:0] md_b;
   logic         md_cancel;
   logic         mf_rd;
   logic         mt_we;
   logic         mt_sel;
   logic [W-1:0] mt_data;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         md_busy;
   logic         md_done;
   logic         md_stall;

   // Pipeline side: issues ops and HI/LO accesses, observes results and stall.
   modport master (
      output md_start, md_op, md_a, md_b, md_cancel, mf_rd, mt_we, mt_sel, mt_data,
      input  hi, lo, md_busy, md_done, md_stall
   );

   // Sequencer side.
   modport slave (
      input  md_start, md_op, md_a, md_b, md_cancel, mf_rd, mt_we, mt_sel, mt_data,
      output hi, lo, md_busy, md_done, md_stall
   );
endinterface
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : md_sched
//  Description : Iterative MULTU/DIVU sequencer owning HI/LO. One result bit
//                per cycle; raises md_stall on hazards while busy.
//                Optional macro MD_EARLY_OUT_EN: MULTU stops as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0  initial release
// ============================================================================
module md_sched #(
   parameter int W  = 32,
   parameter int CW = 6
) (
   input wire        clk,
   input wire        rst,
   md_sched_if.slave bus
);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   logic [0:0]     r_state;
   logic [0:0]     w_state_nxt;
   logic           r_op;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_opa;
   logic [W-1:0]   r_opb;
   logic [W-1:0]   r_hi;
   logic [W-1:0]   r_lo;
   logic           r_done;

   logic           w_busy;
   logic           w_accept;
   logic           w_commit;
   logic           w_mt_wr;
   logic           w_last;
   logic           w_early;
   logic [W:0]     w_rem;
   logic           w_ge;
   logic [W-1:0]   w_diff;
   logic [2*W-1:0] w_acc_nxt;

`ifdef MD_EARLY_OUT_EN
   // Remaining multiplier bits above the one consumed this cycle are zero.
   assign w_early = ~r_op & (r_opb[W-1:1] == '0);
`else
   assign w_early = 1'b0;
`endif

   assign w_last = (r_cnt == CW'(1)) | w_early;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state: accept when idle, leave RUN on terminal count or flush.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (bus.md_start & ~bus.md_cancel) w_state_nxt = c_RUN;
         c_RUN:   if (bus.md_cancel | w_last)        w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Control decode; a flush in the final cycle suppresses the commit.
   always_comb begin
      w_busy   = 1'b0;
      w_accept = 1'b0;
      w_commit = 1'b0;
      w_mt_wr  = 1'b0;
      case (r_state)
         c_IDLE: begin
            w_accept = bus.md_start & ~bus.md_cancel;
            w_mt_wr  = bus.mt_we;
         end
         c_RUN: begin
            w_busy   = 1'b1;
            w_commit = w_last & ~bus.md_cancel;
         end
         default: ;
      endcase
   end

   // One iteration: restoring-divide step (MSB first) or shift-add step (LSB first).
   always_comb begin
      w_rem  = r_acc[2*W-1:W-1];
      w_ge   = (w_rem >= {1'b0, r_opb});
      w_diff = w_rem[W-1:0] - r_opb;
      if (r_op)
         w_acc_nxt = w_ge ? {w_diff, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};
      else
         w_acc_nxt = r_acc + (r_opb[0] ? r_opa : '0);
   end

   // Datapath, counter and HI/LO; MT write and accept may share an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op   <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opa  <= '0;
         r_opb  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_mt_wr) begin
            if (bus.mt_sel) r_hi <= bus.mt_data;
            else            r_lo <= bus.mt_data;
         end
         if (w_accept) begin
            r_op  <= bus.md_op;
            r_cnt <= CW'(W);
            r_opa <= {{W{1'b0}}, bus.md_a};
            r_opb <= bus.md_b;
            // Dividend sits in the low half and shifts up; product starts at zero.
            r_acc <= bus.md_op ? {{W{1'b0}}, bus.md_a} : '0;
         end else if (w_busy) begin
            if (bus.md_cancel | w_last) r_cnt <= '0;
            else                        r_cnt <= r_cnt - CW'(1);
            r_acc <= w_acc_nxt;
            if (!r_op) begin
               r_opa <= r_opa << 1;
               r_opb <= r_opb >> 1;
            end
            if (w_commit) begin
               r_hi <= w_acc_nxt[2*W-1:W];
               r_lo <= w_acc_nxt[W-1:0];
            end
         end
      end
   end

   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
   assign bus.md_busy  = w_busy;
   assign bus.md_done  = r_done;
   assign bus.md_stall = w_busy & (bus.md_start | bus.mf_rd | bus.mt_we);

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_sched
//  Description : Self-checking bench for md_sched with a behavioural
//                HI/LO reference model and randomized operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_sched;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   md_sched_if #(.W(W)) bus ();

   md_sched #(.W(W), .CW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference result {HI, LO} from plain arithmetic.
   function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
      if (!op)    return {32'b0, a} * {32'b0, b};
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   // Reference number of RUN cycles.
   function automatic int exp_len(input logic op, input logic [31:0] b);
      int n;
      n = 32;
`ifdef MD_EARLY_OUT_EN
      if (!op) begin
         n = 1;
         for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      end
`endif
      return n;
   endfunction

   // Issue one op from idle and collect what the DUT shows; caller checks.
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [31:0] ohi, output logic [31:0] olo,
                         output logic odone, output logic odone2);
      bus.md_start = 1'b1; bus.md_op = op; bus.md_a = a; bus.md_b = b;
      @(posedge clk); #1;
      bus.md_start = 1'b0;
      cyc = 0;
      while (bus.md_busy === 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      ohi = bus.hi; olo = bus.lo; odone = bus.md_done;
      @(posedge clk); #1;
      odone2 = bus.md_done;
   endtask

   task automatic mt_write(input logic sel, input logic [31:0] d);
      bus.mt_we = 1'b1; bus.mt_sel = sel; bus.mt_data = d;
      @(posedge clk); #1;
      bus.mt_we = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.hi !== 32'h0)     begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0)     begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
      checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.md_busy); end
      checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.md_done); end
      checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.md_stall); end
      rst  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.md_done !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_release_done got %b exp 0", seen); end
   endtask

   task automatic test_mt();
      mt_write(1'b0, 32'hA5A5_0001);
      checks++; if (bus.lo !== 32'hA5A5_0001) begin errors++; $display("FAIL mt_lo got %h exp a5a50001", bus.lo); end
      checks++; if (bus.hi !== 32'h0)         begin errors++; $display("FAIL mt_hi_untouched got %h exp 0", bus.hi); end
      mt_write(1'b1, 32'h1234_5678);
      checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mt_hi got %h exp 12345678", bus.hi); end
   endtask

   task automatic test_mult_max();
      int cyc; logic [31:0] h, l; logic d1, d2;
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, h, l, d1, d2);
      checks++; if (cyc !== 32)          begin errors++; $display("FAIL mulmax_cycles got %0d exp 32", cyc); end
      checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulmax_hi got %h exp fffffffe", h); end
      checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL mulmax_lo got %h exp 00000001", l); end
      checks++; if (d1 !== 1'b1)         begin errors++; $display("FAIL mulmax_done got %b exp 1", d1); end
      checks++; if (d2 !== 1'b0)         begin errors++; $display("FAIL mulmax_done_pulse got %b exp 0", d2); end
   endtask

   task automatic test_div();
      int cyc; logic [31:0] h, l; logic d1, d2;
      run_op(1'b1, 32'd100, 32'd7, cyc, h, l, d1, d2);
      checks++; if (l !== 32'd14) begin errors++; $display("FAIL div100_7_lo got %0d exp 14", l); end
      checks++; if (h !== 32'd2)  begin errors++; $display("FAIL div100_7_hi got %0d exp 2", h); end
      checks++; if (cyc !== 32)   begin errors++; $display("FAIL div_cycles got %0d exp 32", cyc); end
      run_op(1'b1, 32'd5, 32'd0, cyc, h, l, d1, d2);
      checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div5_0_lo got %h exp ffffffff", l); end
      checks++; if (h !== 32'd5)         begin errors++; $display("FAIL div5_0_hi got %h exp 5", h); end
   endtask

   task automatic test_early_out();
      int cyc; logic [31:0] h, l; logic d1, d2;
      run_op(1'b0, 32'd6, 32'd3, cyc, h, l, d1, d2);
      checks++; if (cyc !== exp_len(1'b0, 32'd3)) begin errors++; $display("FAIL mul6x3_cycles got %0d exp %0d", cyc, exp_len(1'b0, 32'd3)); end
      checks++; if (l !== 32'd18) begin errors++; $display("FAIL mul6x3_lo got %0d exp 18", l); end
      checks++; if (h !== 32'd0)  begin errors++; $display("FAIL mul6x3_hi got %0d exp 0", h); end
      run_op(1'b0, 32'hDEAD_BEEF, 32'd0, cyc, h, l, d1, d2);
      checks++; if (cyc !== exp_len(1'b0, 32'd0)) begin errors++; $display("FAIL mulx0_cycles got %0d exp %0d", cyc, exp_len(1'b0, 32'd0)); end
      checks++; if ({h, l} !== 64'd0) begin errors++; $display("FAIL mulx0_result got %h exp 0", {h, l}); end
   endtask

   task automatic test_stall();
      int n; logic [31:0] a, b; logic [63:0] r;
      a = $urandom; b = $urandom;
      r = ref_result(1'b0, a, b);
      bus.md_start = 1'b1; bus.md_op = 1'b0; bus.md_a = a; bus.md_b = b;
      @(posedge clk); #1;
      bus.md_start = 1'b0; bus.mf_rd = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.md_stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== exp_len(1'b0, b)) begin errors++; $display("FAIL mflo_stall_cycles got %0d exp %0d", n, exp_len(1'b0, b)); end
      checks++; if (bus.lo !== r[31:0])     begin errors++; $display("FAIL mflo_value got %h exp %h", bus.lo, r[31:0]); end
      checks++; if (bus.md_done !== 1'b1)   begin errors++; $display("FAIL mflo_done got %b exp 1", bus.md_done); end
      @(posedge clk); #1;
      bus.mf_rd = 1'b0;
   endtask

   task automatic test_cancel();
      mt_write(1'b1, 32'd7);
      mt_write(1'b0, 32'd9);
      bus.md_start = 1'b1; bus.md_op = 1'b0; bus.md_a = $urandom; bus.md_b = 32'h8000_0001 | $urandom;
      @(posedge clk); #1;
      bus.md_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.md_cancel = 1'b1;
      @(posedge clk); #1;
      bus.md_cancel = 1'b0;
      checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL cancel_idle got busy %b exp 0", bus.md_busy); end
      checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL cancel_nodone got %b exp 0", bus.md_done); end
      checks++; if (bus.hi !== 32'd7 || bus.lo !== 32'd9) begin errors++; $display("FAIL cancel_hilo got %h/%h exp 7/9", bus.hi, bus.lo); end
      @(posedge clk); #1;
      checks++; if (bus.md_done !== 1'b0 || bus.lo !== 32'd9) begin errors++; $display("FAIL cancel_later got done %b lo %h exp 0/9", bus.md_done, bus.lo); end
      bus.md_start = 1'b1; bus.md_cancel = 1'b1;
      @(posedge clk); #1;
      bus.md_start = 1'b0; bus.md_cancel = 1'b0;
      checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL cancel_blocks_accept got busy %b exp 0", bus.md_busy); end
   endtask

   task automatic test_back_to_back();
      int n, cyc; logic [31:0] a1, b1, a2, b2; logic [63:0] r1, r2;
      a1 = $urandom; b1 = $urandom_range(1, 65535); a2 = $urandom; b2 = $urandom_range(1, 1000);
      r1 = ref_result(1'b0, a1, b1);
      r2 = ref_result(1'b1, a2, b2);
      bus.md_start = 1'b1; bus.md_op = 1'b0; bus.md_a = a1; bus.md_b = b1;
      @(posedge clk); #1;
      bus.md_op = 1'b1; bus.md_a = a2; bus.md_b = b2;
      n = 0;
      @(negedge clk);
      while (bus.md_stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== exp_len(1'b0, b1)) begin errors++; $display("FAIL b2b_stall got %0d exp %0d", n, exp_len(1'b0, b1)); end
      checks++; if ({bus.hi, bus.lo} !== r1) begin errors++; $display("FAIL b2b_first got %h exp %h", {bus.hi, bus.lo}, r1); end
      checks++; if (bus.md_done !== 1'b1)    begin errors++; $display("FAIL b2b_done got %b exp 1", bus.md_done); end
      @(posedge clk); #1;
      bus.md_start = 1'b0;
      checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got busy %b exp 1", bus.md_busy); end
      cyc = 0;
      while (bus.md_busy === 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_second_cycles got %0d exp 32", cyc); end
      checks++; if ({bus.hi, bus.lo} !== r2) begin errors++; $display("FAIL b2b_second got %h exp %h", {bus.hi, bus.lo}, r2); end
      @(posedge clk); #1;
   endtask

   task automatic test_mt_accept();
      int cyc; logic [31:0] a, b; logic [63:0] r;
      a = $urandom; b = $urandom;
      r = ref_result(1'b0, a, b);
      bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'hCAFE_F00D;
      bus.md_start = 1'b1; bus.md_op = 1'b0; bus.md_a = a; bus.md_b = b;
      @(posedge clk); #1;
      bus.mt_we = 1'b0; bus.md_start = 1'b0;
      checks++; if (bus.hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL mt_accept_hi got %h exp cafef00d", bus.hi); end
      checks++; if (bus.md_busy !== 1'b1)     begin errors++; $display("FAIL mt_accept_busy got %b exp 1", bus.md_busy); end
      cyc = 0;
      while (bus.md_busy === 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if ({bus.hi, bus.lo} !== r) begin errors++; $display("FAIL mt_accept_result got %h exp %h", {bus.hi, bus.lo}, r); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int cyc; logic [31:0] h, l, a, b; logic d1, d2, op; logic [63:0] r;
      for (int i = 0; i < 24; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(0, 255);
            default: b = $urandom;
         endcase
         r = ref_result(op, a, b);
         run_op(op, a, b, cyc, h, l, d1, d2);
         checks++; if (cyc !== exp_len(op, b)) begin errors++; $display("FAIL rand_cycles op %b a %h b %h got %0d exp %0d", op, a, b, cyc, exp_len(op, b)); end
         checks++; if ({h, l} !== r) begin errors++; $display("FAIL rand_result op %b a %h b %h got %h exp %h", op, a, b, {h, l}, r); end
         checks++; if (d1 !== 1'b1 || d2 !== 1'b0) begin errors++; $display("FAIL rand_done got %b%b exp 10", d1, d2); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic seen;
      bus.md_start = 1'b1; bus.md_op = 1'b1; bus.md_a = $urandom; bus.md_b = $urandom_range(1, 99);
      @(posedge clk); #1;
      bus.md_start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.md_busy); end
      checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h/%h exp 0/0", bus.hi, bus.lo); end
      @(posedge clk); #1;
      rst  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_commit got activity %b exp 0", seen); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.md_start = 1'b0; bus.md_op = 1'b0; bus.md_a = '0; bus.md_b = '0;
      bus.md_cancel = 1'b0; bus.mf_rd = 1'b0; bus.mt_we = 1'b0; bus.mt_sel = 1'b0; bus.mt_data = '0;
      test_reset();
      test_mt();
      test_mult_max();
      test_div();
      test_early_out();
      test_stall();
      test_cancel();
      test_back_to_back();
      test_mt_accept();
      test_random();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
